dht11_reader: RTL and testbench
===============================

# dht11_reader

Single-wire host controller that reads one 40-bit frame from the DHT11 humidity/temperature sensor and presents decoded, checksum-verified bytes to the farm control logic. It drives the sensor pad open-drain: pull low, then release and decode. Its humidity/temperature outputs feed the threshold compare that selects servo and pump setpoints. Runs on the 50 MHz system clock; all durations below are clock cycles.

## Interface
- START_LOW_CYC, 900000, host start pulse length (18 ms)
- BIT_THRESH_CYC, 2500, high-phase length above which a bit decodes as 1 (50 us)
- TIMEOUT_CYC, 10000, maximum cycles in any sensor-wait state (200 us)
- HOLDOFF_CYC, 50000000, minimum idle time after a transaction before the next start (1 s)

- clk  in  1  system clock, 50 MHz, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one read; sampled only in IDLE
- dht_in  in  1  pad level from sensor (asynchronous, pulled up externally)
- dht_oe  out  1  1 = drive pad low, 0 = release (tri-state)
- busy  out  1  high from accepted start until holdoff ends
- valid  out  1  one-cycle pulse: new good frame on data outputs
- error  out  1  one-cycle pulse: transaction failed
- err_code  out  2  01 no response, 10 bit timeout, 11 checksum mismatch; held until next error
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  last good frame bytes

## Operation
- dht_in through 2-FF synchronizer (reset value 1); rise/fall detected on synchronized level vs. previous sample.
- FSM states and transitions:
  - IDLE: start=1 -> START_LOW, counter cleared.
  - START_LOW: dht_oe=1 for exactly START_LOW_CYC cycles -> RELEASE.
  - RELEASE: dht_oe=0; wait fall -> RESP_LOW.
  - RESP_LOW: wait rise -> RESP_HIGH.
  - RESP_HIGH: wait fall -> BIT_LOW, bit index 0.
  - BIT_LOW: wait rise -> BIT_HIGH, high counter cleared.
  - BIT_HIGH: count cycles while high; on fall, bit = (count > BIT_THRESH_CYC). Shift into 40-bit register MSB first. Index 39 -> CHECK, else -> BIT_LOW.
  - CHECK: compare byte4 with (byte0+byte1+byte2+byte3) mod 256 -> HOLDOFF.
  - HOLDOFF: dht_oe=0, count HOLDOFF_CYC -> IDLE.
- Timeouts: counter reset on every state entry. Count reaching TIMEOUT_CYC in RELEASE, RESP_LOW or RESP_HIGH -> error, code 01. In BIT_LOW or BIT_HIGH -> error, code 10. Both go to HOLDOFF.
- Checksum match: load hum_int=byte0, hum_dec=byte1, temp_int=byte2, temp_dec=byte3; pulse valid. Mismatch: data outputs unchanged; pulse error, code 11.
- Data outputs change only on a good frame. Every transaction ends in exactly one valid or error pulse.
- start outside IDLE is ignored and not queued.

## Timing
- Reset values: dht_oe=0, busy=0, valid=0, error=0, err_code=00, all data bytes 0x00, state IDLE.
- start high in IDLE at edge N -> busy=1 and dht_oe=1 at edge N+1. dht_oe stays high for START_LOW_CYC cycles.
- Synchronizer latency is 2 cycles. Edge-to-decision is 3 cycles after the pad transition.
- Last bit's falling edge -> CHECK -> valid/error pulse registered on the following edge. Data bytes update on the same edge as valid.
- busy drops on the edge HOLDOFF ends. start sampled on that same edge is ignored; start on the next edge is accepted.
- rst_n low mid-transaction: immediate return to reset values, dht_oe released asynchronously. Partial frame is discarded.
- Glitch-free pad: dht_oe is a registered output.

## Test plan
Sim parameters: START_LOW_CYC=100, BIT_THRESH_CYC=20, TIMEOUT_CYC=80, HOLDOFF_CYC=50.
- Good frame: sensor model answers 0x37,0x00,0x19,0x05,0x55 (0 bits high 14 cycles, 1 bits high 35) -> dht_oe high exactly 100 cycles; single valid pulse; hum_int=0x37, temp_int=0x19, temp_dec=0x05; busy low 50 cycles after CHECK.
- Checksum error: same frame with checksum 0x56 -> error pulse, err_code=11, data outputs keep previous values, no valid.
- No response: pad stays high after release -> error 80 cycles after release, err_code=01, dht_oe never re-asserts.
- Stuck bit: sensor holds pad low during bit 17 -> error, err_code=10, shift register discarded.
- start while busy, plus boundary bit: start pulsed mid-frame is ignored and no second start pulse appears; a high phase of exactly 20 cycles decodes as 0 and one of 21 cycles decodes as 1.
- Reset mid-frame: rst_n low during bit 10 -> dht_oe=0 and busy=0 immediately, outputs at reset values; a subsequent start runs a full good frame.

Source files
------------

// File: rtl/dht11_reader.sv
// DHT11 single-wire host controller.
// Pulls the pad low for the start pulse, then releases it and decodes the
// sensor's response and 40 data bits. A frame whose checksum matches is
// published on the data outputs. Every transaction ends with exactly one
// valid or error pulse, followed by a mandatory idle holdoff period.
module dht11_reader #(
   parameter int START_LOW_CYC  = 900000,
   parameter int BIT_THRESH_CYC = 2500,
   parameter int TIMEOUT_CYC    = 10000,
   parameter int HOLDOFF_CYC    = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       busy,
   output logic       valid,
   output logic       error,
   output logic [1:0] err_code,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec
);

   // state      | meaning
   // IDLE       | waiting for start
   // START_LOW  | host drives pad low for the start pulse
   // RELEASE    | pad released, waiting for sensor to pull low
   // RESP_LOW   | sensor response low phase
   // RESP_HIGH  | sensor response high phase
   // BIT_LOW    | low lead-in of a data bit
   // BIT_HIGH   | high phase of a data bit, length decides 0/1
   // CHECK      | verify checksum of the captured frame
   // HOLDOFF    | mandatory idle time before the next start
   typedef enum logic [3:0] {
      IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
      BIT_LOW, BIT_HIGH, CHECK, HOLDOFF
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] tmr, tmr_nxt;
   logic [5:0]  bit_idx, bit_idx_nxt;
   logic [39:0] shreg, shreg_nxt;
   logic        done_ok, done_err;
   logic [1:0]  code_nxt;
   logic        dht_s1, dht_s2, dht_prev;
   logic        rise, fall;
   logic        tmr_zero;
   logic        hi_bit;
   logic [7:0]  sum;

   assign rise     = dht_s2 & ~dht_prev;
   assign fall     = ~dht_s2 & dht_prev;
   assign tmr_zero = (tmr == 32'd0);
   // The timer was loaded with TIMEOUT_CYC-1 on entry, so elapsed high
   // cycles at the falling-edge decision are TIMEOUT_CYC - tmr.
   assign hi_bit   = (32'(TIMEOUT_CYC) - tmr) > 32'(BIT_THRESH_CYC);
   assign sum      = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

   // Two-flop synchronizer for the pad, idle-high, plus previous sample for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dht_s1   <= 1'b1;
         dht_s2   <= 1'b1;
         dht_prev <= 1'b1;
      end else begin
         dht_s1   <= dht_in;
         dht_s2   <= dht_s1;
         dht_prev <= dht_s2;
      end
   end

   // Next-state, timer reload, bit capture and completion decisions
   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr_zero ? tmr : tmr - 32'd1;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      done_ok     = 1'b0;
      done_err    = 1'b0;
      code_nxt    = err_code;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = START_LOW;
               shreg_nxt = '0;
            end
         end
         START_LOW: begin
            if (tmr_zero) state_nxt = RELEASE;
         end
         RELEASE: begin
            if (fall) state_nxt = RESP_LOW;
            else if (tmr_zero) begin
               state_nxt = HOLDOFF;
               done_err  = 1'b1;
               code_nxt  = 2'b01;
            end
         end
         RESP_LOW: begin
            if (rise) state_nxt = RESP_HIGH;
            else if (tmr_zero) begin
               state_nxt = HOLDOFF;
               done_err  = 1'b1;
               code_nxt  = 2'b01;
            end
         end
         RESP_HIGH: begin
            if (fall) begin
               state_nxt   = BIT_LOW;
               bit_idx_nxt = 6'd0;
            end else if (tmr_zero) begin
               state_nxt = HOLDOFF;
               done_err  = 1'b1;
               code_nxt  = 2'b01;
            end
         end
         BIT_LOW: begin
            if (rise) state_nxt = BIT_HIGH;
            else if (tmr_zero) begin
               state_nxt = HOLDOFF;
               done_err  = 1'b1;
               code_nxt  = 2'b10;
            end
         end
         BIT_HIGH: begin
            if (fall) begin
               shreg_nxt = {shreg[38:0], hi_bit};
               if (bit_idx == 6'd39) state_nxt = CHECK;
               else begin
                  state_nxt   = BIT_LOW;
                  bit_idx_nxt = bit_idx + 6'd1;
               end
            end else if (tmr_zero) begin
               state_nxt = HOLDOFF;
               done_err  = 1'b1;
               code_nxt  = 2'b10;
            end
         end
         CHECK: begin
            state_nxt = HOLDOFF;
            if (shreg[7:0] == sum) done_ok = 1'b1;
            else begin
               done_err = 1'b1;
               code_nxt = 2'b11;
            end
         end
         HOLDOFF: begin
            if (tmr_zero) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Every state entry restarts the down-counter with that state's budget
      if (state_nxt != state) begin
         case (state_nxt)
            START_LOW: tmr_nxt = 32'(START_LOW_CYC - 1);
            HOLDOFF:   tmr_nxt = 32'(HOLDOFF_CYC - 1);
            default:   tmr_nxt = 32'(TIMEOUT_CYC - 1);
         endcase
      end
   end

   // FSM state, timer, bit index and shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tmr     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // Registered outputs: pad enable, busy, result pulses and published bytes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dht_oe   <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         error    <= 1'b0;
         err_code <= 2'b00;
         hum_int  <= 8'h00;
         hum_dec  <= 8'h00;
         temp_int <= 8'h00;
         temp_dec <= 8'h00;
      end else begin
         dht_oe   <= (state_nxt == START_LOW);
         busy     <= (state_nxt != IDLE);
         valid    <= done_ok;
         error    <= done_err;
         err_code <= code_nxt;
         if (done_ok) begin
            hum_int  <= shreg[39:32];
            hum_dec  <= shreg[31:24];
            temp_int <= shreg[23:16];
            temp_dec <= shreg[15:8];
         end
      end
   end

endmodule

// File: tb/tb_dht11_reader.sv
// Testbench for dht11_reader: a behavioural DHT11 sensor drives the
// open-drain pad; expected results come from the frame checksum rule.
module tb_dht11_reader;
   localparam int START_LOW_CYC  = 100;
   localparam int BIT_THRESH_CYC = 20;
   localparam int TIMEOUT_CYC    = 80;
   localparam int HOLDOFF_CYC    = 50;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       sensor_lvl = 1'b1;
   logic       dht_in;
   logic       dht_oe, busy, valid, error;
   logic [1:0] err_code;
   logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

   // Open-drain pad with external pull-up
   assign dht_in = sensor_lvl & ~dht_oe;

   always #5 clk = ~clk;

   dht11_reader #(
      .START_LOW_CYC (START_LOW_CYC),
      .BIT_THRESH_CYC(BIT_THRESH_CYC),
      .TIMEOUT_CYC   (TIMEOUT_CYC),
      .HOLDOFF_CYC   (HOLDOFF_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dht_in(dht_in),
      .dht_oe(dht_oe), .busy(busy), .valid(valid), .error(error),
      .err_code(err_code), .hum_int(hum_int), .hum_dec(hum_dec),
      .temp_int(temp_int), .temp_dec(temp_dec)
   );

   int checks = 0;
   int failures = 0;

   // Monitor: monotonic event counters and timestamps
   int   cyc = 0, n_valid = 0, n_error = 0, n_oe = 0;
   int   cyc_valid = 0, cyc_error = 0, cyc_oe_fall = 0, cyc_busy_fall = 0;
   logic oe_d = 1'b0, busy_d = 1'b0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (valid === 1'b1) begin n_valid <= n_valid + 1; cyc_valid <= cyc; end
      if (error === 1'b1) begin n_error <= n_error + 1; cyc_error <= cyc; end
      if (dht_oe === 1'b1) n_oe <= n_oe + 1;
      if (oe_d && dht_oe === 1'b0) cyc_oe_fall <= cyc;
      if (busy_d && busy === 1'b0) cyc_busy_fall <= cyc;
      oe_d   <= dht_oe;
      busy_d <= busy;
   end

   // Reference model state: last good frame bytes and last error code
   logic [7:0] m_hi = 8'h00, m_hd = 8'h00, m_ti = 8'h00, m_td = 8'h00;
   logic [1:0] m_code = 2'b00;

   // Sensor timing knobs
   int hi_len[40];
   int lo_len = 10;
   int resp_len = 15;
   int sensor_bit = -1;

   function automatic bit frame_good(input logic [39:0] f);
      int s;
      s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      return (s % 256) == int'(f[7:0]);
   endfunction

   function automatic logic [39:0] make_frame(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3,
                                              input bit corrupt);
      int s;
      s = (int'(b0) + int'(b1) + int'(b2) + int'(b3) + (corrupt ? 1 : 0)) % 256;
      return {b0, b1, b2, b3, 8'(s)};
   endfunction

   task automatic model_apply(input logic [39:0] f);
      if (frame_good(f)) begin
         m_hi = f[39:32]; m_hd = f[31:24]; m_ti = f[23:16]; m_td = f[15:8];
      end else m_code = 2'b11;
   endtask

   task automatic set_fixed_lens(input logic [39:0] f, input int h0, input int h1);
      for (int i = 0; i < 40; i++) hi_len[i] = f[39-i] ? h1 : h0;
   endtask

   task automatic set_random_lens(input logic [39:0] f);
      for (int i = 0; i < 40; i++)
         hi_len[i] = f[39-i] ? int'($urandom_range(60, 21)) : int'($urandom_range(20, 5));
      lo_len   = int'($urandom_range(40, 5));
      resp_len = int'($urandom_range(60, 10));
   endtask

   // Behavioural DHT11: waits for host release, answers, then sends 40 bits MSB first
   task automatic sensor_reply(input logic [39:0] f, input int stuck_bit);
      int g;
      g = 0;
      while (dht_oe !== 1'b0 && g < 400) begin @(negedge clk); g++; end
      if (g >= 400) begin
         checks++; failures++;
         $display("FAIL sensor_wait_release dht_oe=%b required=0", dht_oe);
         return;
      end
      repeat (4) @(negedge clk);
      sensor_lvl = 1'b0; repeat (resp_len) @(negedge clk);
      sensor_lvl = 1'b1; repeat (resp_len) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         sensor_bit = i;
         sensor_lvl = 1'b0;
         if (i == stuck_bit) begin
            repeat (200) @(negedge clk);
            sensor_lvl = 1'b1;
            sensor_bit = -1;
            return;
         end
         repeat (lo_len) @(negedge clk);
         sensor_lvl = 1'b1;
         repeat (hi_len[i]) @(negedge clk);
      end
      sensor_lvl = 1'b0; repeat (lo_len) @(negedge clk);
      sensor_lvl = 1'b1;
      sensor_bit = -1;
   endtask

   task automatic do_start;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while (busy !== 1'b0 && g < 6000) begin @(negedge clk); g++; end
      if (g >= 6000) begin
         checks++; failures++;
         $display("FAIL %s_idle_timeout busy=%b required=0", tag, busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run_txn(input logic [39:0] f, input int stuck, input bit respond,
                          input string tag, output int dv, output int de, output int doe);
      int v0, e0, o0;
      v0 = n_valid; e0 = n_error; o0 = n_oe;
      do_start;
      if (respond) sensor_reply(f, stuck);
      wait_idle(tag);
      dv = n_valid - v0; de = n_error - e0; doe = n_oe - o0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if ({dht_oe, busy, valid, error, err_code} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b required=000000", {dht_oe, busy, valid, error, err_code});
      end
      checks++;
      if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got=%h required=00000000", {hum_int, hum_dec, temp_int, temp_dec});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({dht_oe, busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_idle got=%b required=00", {dht_oe, busy});
      end
   endtask

   task automatic test_good_frame;
      logic [39:0] f;
      int v0, e0, o0;
      f = 40'h37_00_19_05_55;
      set_fixed_lens(f, 14, 35);
      lo_len = 10; resp_len = 15;
      v0 = n_valid; e0 = n_error; o0 = n_oe;
      do_start;
      checks++;
      if ({dht_oe, busy} !== 2'b11) begin
         failures++;
         $display("FAIL good_start_latency got=%b required=11", {dht_oe, busy});
      end
      sensor_reply(f, -1);
      wait_idle("good");
      model_apply(f);
      checks++;
      if (n_oe - o0 != START_LOW_CYC) begin
         failures++;
         $display("FAIL good_oe_cycles got=%0d required=%0d", n_oe - o0, START_LOW_CYC);
      end
      checks++;
      if (n_valid - v0 != 1 || n_error - e0 != 0) begin
         failures++;
         $display("FAIL good_pulses valid=%0d error=%0d required=1,0", n_valid - v0, n_error - e0);
      end
      checks++;
      if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h37_00_19_05) begin
         failures++;
         $display("FAIL good_data got=%h required=37001905", {hum_int, hum_dec, temp_int, temp_dec});
      end
      checks++;
      if (cyc_busy_fall - cyc_valid != HOLDOFF_CYC) begin
         failures++;
         $display("FAIL good_holdoff got=%0d required=%0d", cyc_busy_fall - cyc_valid, HOLDOFF_CYC);
      end
   endtask

   task automatic test_checksum_error;
      logic [39:0] f;
      int dv, de, doe;
      f = 40'h37_00_19_05_56;
      set_fixed_lens(f, 14, 35);
      run_txn(f, -1, 1'b1, "csum", dv, de, doe);
      model_apply(f);
      checks++;
      if (dv != 0 || de != 1) begin
         failures++;
         $display("FAIL csum_pulses valid=%0d error=%0d required=0,1", dv, de);
      end
      checks++;
      if (err_code !== m_code) begin
         failures++;
         $display("FAIL csum_code got=%b required=%b", err_code, m_code);
      end
      checks++;
      if ({hum_int, hum_dec, temp_int, temp_dec} !== {m_hi, m_hd, m_ti, m_td}) begin
         failures++;
         $display("FAIL csum_data_held got=%h required=%h", {hum_int, hum_dec, temp_int, temp_dec},
                  {m_hi, m_hd, m_ti, m_td});
      end
   endtask

   task automatic test_no_response;
      int dv, de, doe;
      run_txn(40'h0, -1, 1'b0, "noresp", dv, de, doe);
      m_code = 2'b01;
      checks++;
      if (dv != 0 || de != 1) begin
         failures++;
         $display("FAIL noresp_pulses valid=%0d error=%0d required=0,1", dv, de);
      end
      checks++;
      if (err_code !== m_code) begin
         failures++;
         $display("FAIL noresp_code got=%b required=%b", err_code, m_code);
      end
      checks++;
      if (cyc_error - cyc_oe_fall != TIMEOUT_CYC) begin
         failures++;
         $display("FAIL noresp_timeout got=%0d required=%0d", cyc_error - cyc_oe_fall, TIMEOUT_CYC);
      end
      checks++;
      if (doe != START_LOW_CYC) begin
         failures++;
         $display("FAIL noresp_oe_cycles got=%0d required=%0d", doe, START_LOW_CYC);
      end
   endtask

   task automatic test_stuck_bit;
      logic [39:0] f;
      int dv, de, doe;
      f = make_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      set_random_lens(f);
      run_txn(f, 17, 1'b1, "stuck", dv, de, doe);
      m_code = 2'b10;
      checks++;
      if (dv != 0 || de != 1) begin
         failures++;
         $display("FAIL stuck_pulses valid=%0d error=%0d required=0,1", dv, de);
      end
      checks++;
      if (err_code !== m_code) begin
         failures++;
         $display("FAIL stuck_code got=%b required=%b", err_code, m_code);
      end
      checks++;
      if ({hum_int, hum_dec, temp_int, temp_dec} !== {m_hi, m_hd, m_ti, m_td}) begin
         failures++;
         $display("FAIL stuck_data_held got=%h required=%h", {hum_int, hum_dec, temp_int, temp_dec},
                  {m_hi, m_hd, m_ti, m_td});
      end
   endtask

   task automatic test_busy_start_boundary;
      logic [39:0] f;
      int v0, e0, o0;
      f = make_frame(8'hA5, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      set_fixed_lens(f, BIT_THRESH_CYC, BIT_THRESH_CYC + 1);
      lo_len = 12; resp_len = 20;
      v0 = n_valid; e0 = n_error; o0 = n_oe;
      do_start;
      fork
         sensor_reply(f, -1);
         begin : mid_frame_start
            int g;
            g = 0;
            while (sensor_bit != 5 && g < 3000) begin @(negedge clk); g++; end
            if (g >= 3000) begin
               checks++; failures++;
               $display("FAIL busy_wait_bit5 got=%0d required=5", sensor_bit);
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      wait_idle("busy");
      model_apply(f);
      checks++;
      if (n_valid - v0 != 1 || n_error - e0 != 0) begin
         failures++;
         $display("FAIL boundary_pulses valid=%0d error=%0d required=1,0", n_valid - v0, n_error - e0);
      end
      checks++;
      if ({hum_int, hum_dec, temp_int, temp_dec} !== f[39:8]) begin
         failures++;
         $display("FAIL boundary_data got=%h required=%h", {hum_int, hum_dec, temp_int, temp_dec}, f[39:8]);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || n_oe - o0 != START_LOW_CYC) begin
         failures++;
         $display("FAIL busy_start_ignored busy=%b oe_cycles=%0d required=0,%0d", busy, n_oe - o0,
                  START_LOW_CYC);
      end
   endtask

   task automatic test_random_frames;
      logic [39:0] f;
      int dv, de, doe;
      bit good;
      for (int k = 0; k < 6; k++) begin
         f = make_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         set_random_lens(f);
         good = frame_good(f);
         run_txn(f, -1, 1'b1, "rand", dv, de, doe);
         model_apply(f);
         checks++;
         if (dv != (good ? 1 : 0) || de != (good ? 0 : 1)) begin
            failures++;
            $display("FAIL rand%0d_pulses valid=%0d error=%0d required=%0d,%0d", k, dv, de,
                     good ? 1 : 0, good ? 0 : 1);
         end
         checks++;
         if ({hum_int, hum_dec, temp_int, temp_dec} !== {m_hi, m_hd, m_ti, m_td}) begin
            failures++;
            $display("FAIL rand%0d_data got=%h required=%h", k, {hum_int, hum_dec, temp_int, temp_dec},
                     {m_hi, m_hd, m_ti, m_td});
         end
         checks++;
         if (err_code !== m_code) begin
            failures++;
            $display("FAIL rand%0d_code got=%b required=%b", k, err_code, m_code);
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [39:0] f;
      int dv, de, doe;
      // Reset while the host is driving the pad: release must be asynchronous
      do_start;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dht_oe, busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_startlow got=%b required=00", {dht_oe, busy});
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      // Reset during bit 10 of a frame
      f = make_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      set_random_lens(f);
      do_start;
      fork
         sensor_reply(f, -1);
         begin : mid_frame_reset
            int g;
            g = 0;
            while (sensor_bit != 10 && g < 3000) begin @(negedge clk); g++; end
            if (g >= 3000) begin
               checks++; failures++;
               $display("FAIL reset_wait_bit10 got=%0d required=10", sensor_bit);
            end
            rst_n = 1'b0;
            #1;
            checks++;
            if ({dht_oe, busy, valid, error, err_code} !== 6'b0) begin
               failures++;
               $display("FAIL reset_mid_ctrl got=%b required=000000", {dht_oe, busy, valid, error, err_code});
            end
            checks++;
            if ({hum_int, hum_dec, temp_int, temp_dec} !== 32'h0) begin
               failures++;
               $display("FAIL reset_mid_data got=%h required=00000000", {hum_int, hum_dec, temp_int, temp_dec});
            end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      m_hi = 8'h00; m_hd = 8'h00; m_ti = 8'h00; m_td = 8'h00; m_code = 2'b00;
      repeat (5) @(negedge clk);
      f = make_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      set_random_lens(f);
      run_txn(f, -1, 1'b1, "post_reset", dv, de, doe);
      model_apply(f);
      checks++;
      if (dv != 1 || de != 0) begin
         failures++;
         $display("FAIL post_reset_pulses valid=%0d error=%0d required=1,0", dv, de);
      end
      checks++;
      if ({hum_int, hum_dec, temp_int, temp_dec} !== {m_hi, m_hd, m_ti, m_td}) begin
         failures++;
         $display("FAIL post_reset_data got=%h required=%h", {hum_int, hum_dec, temp_int, temp_dec},
                  {m_hi, m_hd, m_ti, m_td});
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset;
      test_good_frame;
      test_checksum_error;
      test_no_response;
      test_stuck_bit;
      test_busy_start_boundary;
      test_random_frames;
      test_reset_mid_frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog sim_time=%0t required=finish_before_limit", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
